// File: rtl/ccd_scan_averager.sv
// Per-pixel scan averager: accumulates 2^k CCD scans in an accumulator RAM and
// emits one rounded 16-bit average per pixel on the last scan of each group.
module ccd_scan_averager #(
    parameter int unsigned NPIX     = 2048,
    parameter int unsigned IDX_W    = 11,
    parameter int unsigned MAX_LOG2 = 4,
    parameter int unsigned ACC_W    = 20
) (
    input  logic              sys_2xclk,
    input  logic              xreset,
    input  logic              scan_start,
    input  logic [2:0]        avg_log2,
    input  logic [15:0]       pix_di,
    input  logic              pix_valid,
    input  logic              err_clr,
    output logic [15:0]       pix_do,
    output logic              pix_do_valid,
    output logic              scan_done,
    output logic              err_overrun,
    output logic              err_short
);

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned K_W    = 3;
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned SCNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // control state
    logic [1:0]        state;
    logic [CNT_W-1:0]  idx;
    logic [SCNT_W-1:0] scnt;
    logic [K_W-1:0]    k_l;

    // next-state and per-pixel decode
    logic [1:0]        state_nx;
    logic [CNT_W-1:0]  idx_nx;
    logic [SCNT_W-1:0] scnt_nx;
    logic [K_W-1:0]    k_nx;
    logic [1:0]        eff_state_c;
    logic [CNT_W-1:0]  eff_idx_c;
    logic [SCNT_W-1:0] eff_scnt_c;
    logic [K_W-1:0]    eff_k_c;
    logic [K_W-1:0]    k_clamp_c;
    logic [SCNT_W-1:0] grp_last_c;
    logic              accept_c;
    logic              first_c;
    logic              last_c;
    logic              end_c;
    logic              set_ovr_c;
    logic              set_short_c;

    // pipeline stage 1 (pixel registered, RAM read in flight)
    logic              s1_valid;
    logic [PIX_W-1:0]  s1_p;
    logic [IDX_W-1:0]  s1_addr;
    logic              s1_first;
    logic              s1_last;
    logic              s1_end;
    logic [K_W-1:0]    s1_k;

    // accumulator RAM with synchronous read
    logic [ACC_W-1:0]  ram [NPIX];
    logic [ACC_W-1:0]  ram_q;

    // stage 2 arithmetic
    logic [ACC_W-1:0]  sum_c;
    logic [ACC_W-1:0]  half_c;
    logic [PIX_W-1:0]  rnd_c;

    // clamp requested averaging depth to the supported maximum
    assign k_clamp_c = (avg_log2 > K_W'(MAX_LOG2)) ? K_W'(MAX_LOG2) : avg_log2;

    // state register
    always_ff @(posedge sys_2xclk or negedge xreset) begin
        if (!xreset) begin
            state <= ST_IDLE;
            idx   <= '0;
            scnt  <= '0;
            k_l   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            scnt  <= scnt_nx;
            k_l   <= k_nx;
        end
    end

    // next-state: scan_start is applied first, then the pixel of the same cycle
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        scnt_nx     = scnt;
        k_nx        = k_l;
        eff_state_c = state;
        eff_idx_c   = idx;
        eff_scnt_c  = scnt;
        eff_k_c     = k_l;
        grp_last_c  = '0;
        accept_c    = 1'b0;
        first_c     = 1'b0;
        last_c      = 1'b0;
        end_c       = 1'b0;
        set_ovr_c   = 1'b0;
        set_short_c = 1'b0;

        if (scan_start) begin
            // restart in the middle of a scan discards the partial group
            if ((state == ST_ACCUM) && (idx != '0)) begin
                set_short_c = 1'b1;
                eff_scnt_c  = '0;
            end
            if (eff_scnt_c == '0) begin
                eff_k_c = k_clamp_c;
            end
            eff_idx_c   = '0;
            eff_state_c = ST_ACCUM;
        end

        grp_last_c = SCNT_W'((32'd1 << eff_k_c) - 32'd1);
        state_nx   = eff_state_c;
        idx_nx     = eff_idx_c;
        scnt_nx    = eff_scnt_c;
        k_nx       = eff_k_c;

        if (pix_valid) begin
            if (eff_state_c == ST_ACCUM) begin
                accept_c = 1'b1;
                first_c  = (eff_scnt_c == '0);
                last_c   = (eff_scnt_c == grp_last_c);
                end_c    = (eff_idx_c == CNT_W'(NPIX - 1));
                idx_nx   = eff_idx_c + CNT_W'(1);
                if (end_c) begin
                    state_nx = ST_WAIT;
                    scnt_nx  = last_c ? '0 : (eff_scnt_c + SCNT_W'(1));
                end
            end else if (eff_state_c == ST_WAIT) begin
                set_ovr_c = 1'b1;
            end
        end
    end

    // stage 1: register the accepted pixel and its scan-position tags
    always_ff @(posedge sys_2xclk or negedge xreset) begin
        if (!xreset) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_addr  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_end   <= 1'b0;
            s1_k     <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_p     <= pix_di;
                s1_addr  <= IDX_W'(eff_idx_c);
                s1_first <= first_c;
                s1_last  <= last_c;
                s1_end   <= end_c;
                s1_k     <= eff_k_c;
            end
        end
    end

    // accumulator RAM: read for the incoming pixel, write back non-final sums
    always_ff @(posedge sys_2xclk) begin
        if (accept_c) begin
            ram_q <= ram[IDX_W'(eff_idx_c)];
        end
        if (s1_valid && !s1_last) begin
            ram[s1_addr] <= sum_c;
        end
    end

    // stage 2 arithmetic: accumulate and round-half-up divide by 2^k
    always_comb begin
        sum_c  = s1_first ? ACC_W'(s1_p) : (ram_q + ACC_W'(s1_p));
        half_c = ACC_W'((32'd1 << s1_k) >> 1);
        rnd_c  = PIX_W'((sum_c + half_c) >> s1_k);
    end

    // output register: averaged pixel on the last scan of a group
    always_ff @(posedge sys_2xclk or negedge xreset) begin
        if (!xreset) begin
            pix_do       <= '0;
            pix_do_valid <= 1'b0;
            scan_done    <= 1'b0;
        end else if (s1_valid && s1_last) begin
            pix_do       <= rnd_c;
            pix_do_valid <= 1'b1;
            scan_done    <= s1_end;
        end else begin
            pix_do_valid <= 1'b0;
            scan_done    <= 1'b0;
        end
    end

    // sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge sys_2xclk or negedge xreset) begin
        if (!xreset) begin
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            if (set_ovr_c) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end
            if (set_short_c) begin
                err_short <= 1'b1;
            end else if (err_clr) begin
                err_short <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ccd_scan_averager.md
# ccd_scan_averager

Per-pixel scan averager between the AD7621 capture stage and the CCD pixel FIFO. It accumulates 2^k consecutive CCD scans pixel-by-pixel in an internal accumulator RAM. On the last scan of each group it emits one rounded 16-bit average per pixel, which feeds the FIFO write port. With k=0 it is a pass-through with a fixed 2-cycle latency.

## Interface

Parameters:
- NPIX, 2048: pixels per scan (accumulator RAM depth).
- IDX_W, 11: index width; must satisfy 2^IDX_W ≥ NPIX.
- MAX_LOG2, 4: largest k accepted.
- ACC_W, 20: accumulator width, 16+MAX_LOG2.

Ports:
- sys_clk  in  1  single clock domain (sys_2xclk in the top).
- xreset  in  1  asynchronous, active-low reset.
- scan_start  in  1  one-cycle pulse at the start of each scan (from the CCD timing flag_adc_restart).
- avg_log2  in  3  k, the log2 of scans per group; values >MAX_LOG2 clamp to MAX_LOG2.
- pix_di  in  16  ADC pixel sample.
- pix_valid  in  1  pix_di qualifier, one cycle per pixel.
- err_clr  in  1  clears both sticky error flags.
- pix_do  out  16  averaged pixel.
- pix_do_valid  out  1  pix_do qualifier, drives FIFO wr_en.
- scan_done  out  1  one-cycle pulse with the last output pixel of a group.
- err_overrun  out  1  sticky: more than NPIX pixels arrived in one scan.
- err_short  out  1  sticky: scan_start arrived mid-scan.

## Operation

- State: pixel index idx (0..NPIX), scan counter scnt (0..2^k−1), and latched k_l.
- FSM states:
  - IDLE: entered on reset; waits for scan_start.
  - ACCUM: counting pixels of the current scan.
  - WAIT: idx==NPIX, waiting for the next scan_start.
- On scan_start:
  - idx←0.
  - If scnt==0, latch k_l←clamp(avg_log2). avg_log2 changes mid-group have no effect until the next group.
  - Go to ACCUM.
- On scan_start while ACCUM with 0<idx<NPIX (short scan):
  - set err_short;
  - scnt←0;
  - re-latch k_l;
  - idx←0.
  - The partial group is discarded with no outputs.
- pix_valid in ACCUM: RAM read of address idx, then idx←idx+1. When idx reaches NPIX, go to WAIT.
- Pixel write rule, with P = pix_di and A = RAM[idx]:
  - First scan (scnt==0): RAM←P, zero-extended to ACC_W. The previous RAM contents are ignored.
  - Middle scans: RAM←A+P.
  - Last scan (scnt==2^k_l−1): S=A+P, or S=P when k_l=0. Output pix_do = (S + 2^(k_l−1)) >> k_l, or S when k_l=0, and pulse pix_do_valid. The RAM write is don't-care.
- Arithmetic:
  - Unsigned throughout; S < 2^20 always, no wrap.
  - The rounding add fits in ACC_W (max 1048568).
  - The result always fits in 16 bits.
- End of scan: after the pixel at idx=NPIX−1 completes, scnt←scnt+1, or 0 on the last scan. scan_done pulses in the same cycle as the final pix_do_valid of the last scan.
- pix_valid in WAIT or IDLE: the pixel is dropped with no RAM or output effect. In WAIT it also sets err_overrun.
- scan_start and pix_valid in the same cycle: scan_start is applied first, and the pixel is pixel 0 of the new scan.
- err_clr and a new error in the same cycle: the error wins and the flag stays 1.

## Timing

- Reset values: pix_do=0, pix_do_valid=0, scan_done=0, err_overrun=0, err_short=0, idx=0, scnt=0, k_l=0, state IDLE.
  - RAM is not cleared.
  - Reset mid-group aborts the group, and any pipelined output is cancelled.
- Pipeline:
  - Cycle t: pix_valid sampled, RAM read issued, P registered.
  - Cycle t+1: A available (synchronous-read RAM), sum computed, RAM written or output registered.
  - pix_do_valid is high in cycle t+2, i.e. fixed 2-cycle latency, for every k.
- Back-to-back pix_valid on every cycle is supported at full throughput. Read of idx+1 and write of idx never hit the same address.
- A scan_start pulse does not flush the pipeline: in-flight pixels of the previous scan complete normally.
- No backpressure. The downstream FIFO full condition is handled outside this block.

## Test plan

- Pass-through: NPIX=8, k=0, scan_start then pixels 100,200,…,800 back-to-back → pix_do identical and in order, each 2 cycles after input; scan_done with the 800 output; no errors.
- Rounding: k=2, 4 scans with every pixel = 100,101,102,103 → no outputs in scans 1–3; in scan 4 every pix_do=102 ((406+2)>>2); one scan_done.
- Full scale: k=4, 16 scans all 0xFFFF → every pix_do=0xFFFF, no wrap. Then k=4 with 15 scans of 0 and one of 15 → pix_do=1 ((15+8)>>4).
- Overrun: k=0, 10 pixels in one scan → 8 outputs, err_overrun=1, pixels 9–10 produce nothing. err_clr → flag returns to 0.
- Short scan and k change:
  - k=1; scan 1 full, then scan_start after 5 pixels of scan 2 → err_short=1, no outputs.
  - avg_log2 changed to 0 mid-scan takes effect at the restart.
  - The next scan emits 8 outputs equal to its inputs.
- Reset and collision: assert xreset in scan 2 of a k=2 group → all outputs 0 immediately. Then scan_start coincident with pix_valid=55, k=0 → pix_do=55 as pixel 0.
